// File: rtl/result_display_driver_pkg.sv
// Shared types and constants for the result display driver: FSM states,
// segment patterns, digit indices and the double-dabble nibble adjust.
package result_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;

    localparam int NBITS = 5;

    // A nibble of 5 or more would pass 9 after the next shift, so pre-correct it by +3.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/result_display_driver_seg7_encode.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; values above 9 go blank.
module seg7_encode
    import result_display_driver_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_driver.sv
// Captures a sign-magnitude result, converts it to BCD by serial double-dabble
// and scans it onto a 3-digit common-anode display (sign, tens, units).
module result_display_driver
    import result_display_driver_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] R,
    input  logic       sign,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy,
    output logic       valid
);

    localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

    state_t           r_state;
    logic [NBITS-1:0] r_shift;
    logic [7:0]       r_bcd;
    logic [2:0]       r_bitcnt;
    logic             r_sign_q;
    logic [3:0]       r_disp_tens;
    logic [3:0]       r_disp_units;
    logic             r_disp_minus;
    logic             r_valid;
    logic             r_busy;
    logic [DW-1:0]    r_div;
    logic [1:0]       r_dig;
    logic [6:0]       r_seg;
    logic [2:0]       r_an;

    logic [7:0]       w_bcd_adj;
    logic [6:0]       w_seg_units;
    logic [6:0]       w_seg_tens;
    logic [1:0]       w_dig_next;
    logic [6:0]       w_seg_next;
    logic [2:0]       w_an_next;
    logic             w_tick;

    assign w_bcd_adj = {dabble_adj(r_bcd[7:4]), dabble_adj(r_bcd[3:0])};
    assign w_tick    = (r_div == DIV_LAST);

    seg7_encode u_enc_units (.i_bcd(r_disp_units), .o_seg(w_seg_units));
    seg7_encode u_enc_tens  (.i_bcd(r_disp_tens),  .o_seg(w_seg_tens));

    // Capture / convert / commit sequencer; loads outside IDLE are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bcd        <= 8'd0;
            r_bitcnt     <= 3'd0;
            r_sign_q     <= 1'b0;
            r_disp_tens  <= 4'd0;
            r_disp_units <= 4'd0;
            r_disp_minus <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift  <= R;
                        r_sign_q <= sign;
                        r_bcd    <= 8'd0;
                        r_bitcnt <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= CONV;
                    end
                end
                CONV: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_bitcnt         <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'(NBITS - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_disp_tens  <= r_bcd[7:4];
                    r_disp_units <= r_bcd[3:0];
                    // Zero magnitude never shows a minus, whatever the sign bit said
                    r_disp_minus <= r_sign_q & (r_bcd != 8'd0);
                    r_valid      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Next digit index and its segment/anode pattern
    always_comb begin
        w_dig_next = DIG_UNITS;
        w_seg_next = SEG_BLANK;
        w_an_next  = 3'b111;
        if (r_dig == DIG_SIGN) begin
            w_dig_next = DIG_UNITS;
        end else begin
            w_dig_next = r_dig + 2'd1;
        end
        if (r_valid) begin
            case (w_dig_next)
                DIG_UNITS: begin
                    w_an_next  = 3'b110;
                    w_seg_next = w_seg_units;
                end
                DIG_TENS: begin
                    w_an_next  = 3'b101;
                    w_seg_next = (BLANK_LZ && (r_disp_tens == 4'd0)) ? SEG_BLANK : w_seg_tens;
                end
                DIG_SIGN: begin
                    w_an_next  = 3'b011;
                    w_seg_next = r_disp_minus ? SEG_MINUS : SEG_BLANK;
                end
                default: begin
                    w_an_next  = 3'b111;
                    w_seg_next = SEG_BLANK;
                end
            endcase
        end else begin
            w_an_next  = 3'b111;
            w_seg_next = SEG_BLANK;
        end
    end

    // Free-running scan divider; digit and outputs advance together on terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_dig <= DIG_UNITS;
            r_seg <= SEG_BLANK;
            r_an  <= 3'b111;
        end else begin
            if (w_tick) begin
                r_div <= '0;
                r_dig <= w_dig_next;
                r_seg <= w_seg_next;
                r_an  <= w_an_next;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign busy  = r_busy;
    assign valid = r_valid;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed scoreboard bench for result_display_driver with a fast scan divider.
module tb_result_display_driver;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [4:0] R     = 5'd0;
    logic       sign  = 1'b0;
    logic [6:0] seg, seg0;
    logic [2:0] an, an0;
    logic       busy, busy0, valid, valid0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] u;
        logic [6:0] t;
        logic [6:0] s;
    } exp_t;
    exp_t sb[$];

    result_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .R(R), .sign(sign),
        .seg(seg), .an(an), .busy(busy), .valid(valid)
    );

    result_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .R(R), .sign(sign),
        .seg(seg0), .an(an0), .busy(busy0), .valid(valid0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int r, input bit s);
        exp_t e;
        e.u = enc(r % 10);
        e.t = ((r / 10) == 0) ? 7'b1111111 : enc(r / 10);
        e.s = (s && (r != 0)) ? 7'b0111111 : 7'b1111111;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int r, input bit s);
        @(negedge clk);
        R    = 5'(r);
        sign = s;
        load = 1'b1;
        sb.push_back(model(r, s));
        @(negedge clk);
        load = 1'b0;
        R    = 5'($urandom);
        sign = 1'($urandom);
    endtask

    task automatic wait_commit(input int n0);
        int n;
        n = n0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 6);
        chk("valid_after_commit", valid, 1);
    endtask

    task automatic check_scan(output logic [6:0] tens0);
        logic [6:0] su, st, ss;
        exp_t e;
        su = 7'bx; st = 7'bx; ss = 7'bx; tens0 = 7'bx;
        repeat (28) begin
            @(negedge clk);
            case (an)
                3'b110:  su = seg;
                3'b101:  begin st = seg; tens0 = seg0; end
                3'b011:  ss = seg;
                default: ;
            endcase
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("units_seg", su, e.u);
            chk("tens_seg",  st, e.t);
            chk("sign_seg",  ss, e.s);
        end
    endtask

    initial begin
        logic [6:0] t0;

        // Reset held with random inputs
        repeat (5) begin
            @(negedge clk);
            load = 1'($urandom);
            R    = 5'($urandom);
            sign = 1'($urandom);
        end
        chk("rst_seg",   seg,   7'b1111111);
        chk("rst_an",    an,    3'b111);
        chk("rst_busy",  busy,  0);
        chk("rst_valid", valid, 0);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        start_load(22, 1'b0);
        wait_commit(0);
        check_scan(t0);

        start_load(4, 1'b0);
        wait_commit(0);
        check_scan(t0);
        chk("tens_no_blank_lz", t0, 7'b1000000);

        start_load(4, 1'b1);
        wait_commit(0);
        check_scan(t0);

        // Second load two cycles into the conversion must be ignored
        @(negedge clk);
        R = 5'd31; sign = 1'b0; load = 1'b1;
        sb.push_back(model(31, 1'b0));
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        R = 5'd9; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_commit(2);
        check_scan(t0);

        start_load(0, 1'b1);
        wait_commit(0);
        check_scan(t0);

        // Asynchronous reset between edges clears outputs immediately
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_seg",   seg,   7'b1111111);
        chk("async_an",    an,    3'b111);
        chk("async_busy",  busy,  0);
        chk("async_valid", valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a conversion: no commit
        R = 5'd22; sign = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midconv_busy",  busy,  0);
        chk("midconv_valid", valid, 0);
        chk("midconv_an",    an,    3'b111);
        chk("midconv_seg",   seg,   7'b1111111);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_commit_valid", valid, 0);
        chk("no_commit_an",    an,    3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
